// File: rtl/pwm_pkg.sv
// Shared types and duty arithmetic for the multi-channel PWM generator.
package pwm_pkg;

  typedef enum logic {
    PWM_DIRECT = 1'b0,
    PWM_FADE   = 1'b1
  } pwm_mode_e;

  function automatic int unsigned clamp_duty(input int unsigned duty, input int unsigned period);
    int unsigned res;
    res = (duty > period) ? period : duty;
    return res;
  endfunction

  // Wide unsigned math so neither the up nor the down step can wrap.
  function automatic int unsigned next_duty(input pwm_mode_e mode, input int unsigned active,
                                            input int unsigned target, input int unsigned step);
    int unsigned res;
    int unsigned up;
    int unsigned dn;
    up  = active + step;
    dn  = (active > step) ? (active - step) : 0;
    res = target;
    if (mode == PWM_FADE) begin
      if (active < target) begin
        res = (up > target) ? target : up;
      end else if (active > target) begin
        res = (dn < target) ? target : dn;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM compare channel: clamped shadow duty, boundary-updated active duty,
// registered compare output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned PERIOD = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             period_end_i,
  input  logic [CNT_W-1:0] fade_step_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [CNT_W-1:0] duty_i,
  input  logic             duty_we_i,
  output logic             pwm_o
);

  logic [CNT_W-1:0] shadow_q;
  logic [CNT_W-1:0] active_q;
  logic [CNT_W-1:0] shadow_d;
  logic [CNT_W-1:0] active_d;

  always_comb begin
    shadow_d = CNT_W'(clamp_duty(32'(duty_i), PERIOD));
    active_d = CNT_W'(next_duty(pwm_mode_e'(mode_i), 32'(active_q), 32'(shadow_q),
                                32'(fade_step_i)));
  end

  // Active reads shadow_q before this edge's write, so a write on the
  // boundary cycle is picked up one period later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_o    <= 1'b0;
    end else begin
      if (duty_we_i) begin
        shadow_q <= shadow_d;
      end
      if (!en_i) begin
        active_q <= shadow_q;
      end else if (period_end_i) begin
        active_q <= active_d;
      end
      pwm_o <= en_i && (count_i < active_q);
    end
  end

endmodule

// File: rtl/pwm_multi_generator.sv
// Multi-channel PWM generator: shared prescaler and period counter feeding
// CHANNELS independent compare channels.
module pwm_multi_generator
  import pwm_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned PERIOD   = 255,
  parameter int unsigned PRESC_W  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic [PRESC_W-1:0]        prescale_i,
  input  logic                      mode_i,
  input  logic [CNT_W-1:0]          fade_step_i,
  input  logic [CHANNELS*CNT_W-1:0] duty_i,
  input  logic [CHANNELS-1:0]       duty_we_i,
  output logic [CHANNELS-1:0]       pwm_o,
  output logic                      period_end_o
);

  logic [PRESC_W-1:0] presc_q;
  logic [CNT_W-1:0]   count_q;
  logic               tick;
  logic               last;

  // >= lets a smaller prescale take effect immediately instead of wrapping.
  assign tick         = en_i && (presc_q >= prescale_i);
  assign last         = (count_q == CNT_W'(PERIOD - 1));
  assign period_end_o = tick && last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      count_q <= '0;
    end else if (!en_i) begin
      presc_q <= '0;
      count_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
      count_q <= last ? '0 : count_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pwm_channel #(
      .CNT_W  (CNT_W),
      .PERIOD (PERIOD)
    ) u_ch (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .en_i         (en_i),
      .mode_i       (mode_i),
      .period_end_i (period_end_o),
      .fade_step_i  (fade_step_i),
      .count_i      (count_q),
      .duty_i       (duty_i[c*CNT_W +: CNT_W]),
      .duty_we_i    (duty_we_i[c]),
      .pwm_o        (pwm_o[c])
    );
  end

endmodule
